// File: rtl/keypad_bcd_entry.sv
// 4x4 matrix keypad scanner with press/release debounce that builds a 4-digit BCD entry {m,c,d,u}.
// Digits shift in from the right; * clears, # deletes the last digit, A-D only report their code.
module keypad_bcd_entry #(
   parameter int SCAN_TICKS     = 27_000,
   parameter int DEBOUNCE_SCANS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row_in,
   output logic [3:0]  col_out,
   output logic [15:0] digito,
   output logic        key_valid,
   output logic [3:0]  key_code
);

   localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
   localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_SCANS);
   localparam logic [DW-1:0] DEB_ONE   = DW'(1);

   localparam logic [1:0] ST_SCAN      = 2'd0;
   localparam logic [1:0] ST_PRESS_DEB = 2'd1;
   localparam logic [1:0] ST_HELD      = 2'd2;
   localparam logic [1:0] ST_REL_DEB   = 2'd3;

   logic [3:0]    row_meta_q;
   logic [3:0]    rs_q;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;

   logic [1:0]    state_q, state_d;
   logic [3:0]    col_q, col_d;
   logic [3:0]    row_lat_q, row_lat_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [15:0]   digito_q, digito_d;
   logic          key_valid_q, key_valid_d;
   logic [3:0]    key_code_q, key_code_d;
   logic [3:0]    new_code;
   logic [3:0]    col_rot;

   // Code for a latched row pattern and the frozen column; the lowest low row wins.
   function automatic logic [3:0] decode_key(input logic [3:0] rows, input logic [3:0] cols);
      logic [1:0] r;
      logic [1:0] c;
      logic [3:0] code;
      r = 2'd3;
      for (int i = 3; i >= 0; i--)
         if (!rows[i]) r = 2'(i);
      c = 2'd0;
      for (int i = 0; i < 4; i++)
         if (!cols[i]) c = 2'(i);
      case ({r, c})
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h2;
         4'd2:    code = 4'h3;
         4'd3:    code = 4'hA;
         4'd4:    code = 4'h4;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h6;
         4'd7:    code = 4'hB;
         4'd8:    code = 4'h7;
         4'd9:    code = 4'h8;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hC;
         4'd12:   code = 4'hE;
         4'd13:   code = 4'h0;
         4'd14:   code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_meta_q <= 4'hF;
         rs_q       <= 4'hF;
      end else begin
         row_meta_q <= row_in;
         rs_q       <= row_meta_q;
      end
   end

   assign tick       = (tick_cnt_q == TICK_LAST);
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   assign col_rot    = {col_q[2:0], col_q[3]};
   assign new_code   = decode_key(row_lat_q, col_q);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_lat_d   = row_lat_q;
      deb_cnt_d   = deb_cnt_q;
      digito_d    = digito_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;

      case (state_q)
         ST_SCAN: begin
            if (tick) begin
               if (rs_q == 4'hF) begin
                  col_d = col_rot;
               end else begin
                  row_lat_d = rs_q;
                  deb_cnt_d = DEB_ONE;
                  state_d   = ST_PRESS_DEB;
               end
            end
         end
         ST_PRESS_DEB: begin
            if (deb_cnt_q == DEB_DONE) begin
               key_valid_d = 1'b1;
               key_code_d  = new_code;
               state_d     = ST_HELD;
               if (new_code <= 4'd9)
                  digito_d = {digito_q[11:0], new_code};
               else if (new_code == 4'hE)
                  digito_d = 16'h0000;
               else if (new_code == 4'hF)
                  digito_d = {4'h0, digito_q[15:4]};
            end else if (tick) begin
               if (rs_q == row_lat_q)
                  deb_cnt_d = deb_cnt_q + DEB_ONE;
               else
                  state_d = ST_SCAN;
            end
         end
         ST_HELD: begin
            if (tick && rs_q == 4'hF) begin
               deb_cnt_d = DEB_ONE;
               state_d   = ST_REL_DEB;
            end
         end
         ST_REL_DEB: begin
            if (deb_cnt_q == DEB_DONE) begin
               col_d   = col_rot;
               state_d = ST_SCAN;
            end else if (tick) begin
               if (rs_q == 4'hF)
                  deb_cnt_d = deb_cnt_q + DEB_ONE;
               else
                  state_d = ST_HELD;
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt_q  <= '0;
         state_q     <= ST_SCAN;
         col_q       <= 4'b1110;
         row_lat_q   <= 4'hF;
         deb_cnt_q   <= '0;
         digito_q    <= 16'h0000;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         state_q     <= state_d;
         col_q       <= col_d;
         row_lat_q   <= row_lat_d;
         deb_cnt_q   <= deb_cnt_d;
         digito_q    <= digito_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
      end
   end

   assign col_out   = col_q;
   assign digito    = digito_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Scoreboard bench for keypad_bcd_entry: a keypad model shorts pressed rows to the driven column,
// stimulus pushes the expected {code, digito} per accepted key, a monitor pops on each key_valid.
module tb_keypad_bcd_entry;

   localparam int SCAN_TICKS     = 4;
   localparam int DEBOUNCE_SCANS = 3;

   typedef struct packed {
      logic [3:0]  code;
      logic [15:0] dig;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [15:0] digito;
   logic        key_valid;
   logic [3:0]  key_code;

   logic [3:0][3:0] pressed;   // pressed[row][col]
   exp_t            exp_q[$];
   exp_t            mon_e;
   int              tests = 0;
   int              fails = 0;

   keypad_bcd_entry #(
      .SCAN_TICKS    (SCAN_TICKS),
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .row_in   (row_in),
      .col_out  (col_out),
      .digito   (digito),
      .key_valid(key_valid),
      .key_code (key_code)
   );

   always #5 clk = ~clk;

   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r] & ~col_out);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && key_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected key_valid: got code %0h digito %0h expected no pulse", key_code, digito);
         end else begin
            mon_e = exp_q.pop_front();
            check("key_code", 32'(key_code), 32'(mon_e.code));
            check("digito", 32'(digito), 32'(mon_e.dig));
         end
      end
   end

   task automatic tick_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_key(input logic [3:0] code, input logic [15:0] dig);
      exp_t e;
      e.code = code;
      e.dig  = dig;
      exp_q.push_back(e);
   endtask

   task automatic press_key(input int r, input int c, input int hold, input int gap);
      pressed[r][c] = 1'b1;
      tick_clk(hold);
      pressed[r][c] = 1'b0;
      tick_clk(gap);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick_clk(1);
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_col;
      pressed = '0;

      // T1: asynchronous reset mid-scan, then the idle column rotation.
      tick_clk(3);
      rst = 1'b1;
      tick_clk(10);
      #2 rst = 1'b0;
      #1;
      check("T1 reset col_out", 32'(col_out), 32'h0000_000E);
      check("T1 reset digito", 32'(digito), 32'h0);
      check("T1 reset key_valid", 32'(key_valid), 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      exp_col = 4'b1110;
      for (int n = 1; n <= 64; n++) begin
         @(posedge clk);
         #1;
         if (n % 4 == 0) exp_col = {exp_col[2:0], exp_col[3]};
         check("T1 col scan", 32'(col_out), 32'(exp_col));
      end

      // T2: digit entry 1..5.
      expect_key(4'h1, 16'h0001); press_key(0, 0, 40, 40);
      expect_key(4'h2, 16'h0012); press_key(0, 1, 40, 40);
      expect_key(4'h3, 16'h0123); press_key(0, 2, 40, 40);
      expect_key(4'h4, 16'h1234); press_key(1, 0, 40, 40);
      expect_key(4'h5, 16'h2345); press_key(1, 1, 40, 40);
      wait_drain("T2 five pulses", 20);

      // T3: bouncing key 7 then a short glitch on key 8.
      expect_key(4'h7, 16'h3457);
      for (int i = 0; i < 10; i++) begin
         pressed[2][0] = ~pressed[2][0];
         tick_clk(3);
      end
      press_key(2, 0, 60, 40);
      press_key(2, 1, 5, 40);
      wait_drain("T3 one pulse", 20);

      // T4: edit keys.
      expect_key(4'hE, 16'h0000); press_key(3, 0, 40, 40);
      expect_key(4'h1, 16'h0001); press_key(0, 0, 40, 40);
      expect_key(4'h2, 16'h0012); press_key(0, 1, 40, 40);
      expect_key(4'h3, 16'h0123); press_key(0, 2, 40, 40);
      expect_key(4'hF, 16'h0012); press_key(3, 2, 40, 40);
      expect_key(4'hE, 16'h0000); press_key(3, 0, 40, 40);
      expect_key(4'hA, 16'h0000); press_key(0, 3, 40, 40);
      wait_drain("T4 edit keys", 20);

      // T5: long hold, second key while held, two rows in one column.
      expect_key(4'h5, 16'h0005);
      pressed[1][1] = 1'b1;
      tick_clk(100);
      pressed[2][2] = 1'b1;
      tick_clk(100);
      pressed[1][1] = 1'b0;
      pressed[2][2] = 1'b0;
      tick_clk(60);
      expect_key(4'h1, 16'h0051);
      pressed[0][0] = 1'b1;
      pressed[2][0] = 1'b1;
      tick_clk(40);
      pressed[0][0] = 1'b0;
      pressed[2][0] = 1'b0;
      tick_clk(40);
      wait_drain("T5 hold and multi-key", 20);

      // T6: reset while a key is held; it is accepted again afterwards.
      expect_key(4'h6, 16'h0516);
      pressed[1][2] = 1'b1;
      wait_drain("T6 first accept", 60);
      tick_clk(8);
      #2 rst = 1'b0;
      #1;
      check("T6 reset col_out", 32'(col_out), 32'h0000_000E);
      check("T6 reset digito", 32'(digito), 32'h0);
      check("T6 reset key_valid", 32'(key_valid), 32'h0);
      tick_clk(3);
      rst = 1'b1;
      expect_key(4'h6, 16'h0006);
      tick_clk(60);
      pressed[1][2] = 1'b0;
      tick_clk(40);
      wait_drain("T6 re-accept", 20);
      check("final key_code held", 32'(key_code), 32'h6);
      check("final digito", 32'(digito), 32'h0006);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
